trng_deserializer: RTL and testbench
====================================

# trng_deserializer

Collects the single-bit random stream produced by the entropy-source selection path (ring-oscillator outputs selected and sampled upstream) and packs it into parallel words. A one-word output register with a valid/ready handshake presents each word to downstream consumers (UART transmitter, display logic). Words completed while the output register is occupied are dropped and counted, never stalling the bit source.

## Interface
- WIDTH, 8, bits per output word (≥2)
- DROP_W, 16, width of the dropped-word counter
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  sampled random bit
- bit_valid  input  1  bit_in is valid this cycle; no backpressure to source
- word_out  output  WIDTH  assembled word, first-received bit in MSB
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out when high with word_valid
- overflow  output  1  sticky: at least one word dropped since reset
- drop_count  output  DROP_W  number of dropped words, saturating at all-ones

## Operation
- Shift register shreg (WIDTH-1 bits used) and bit counter cnt (0..WIDTH-1).
- bit_valid=1: shreg <= {shreg, bit_in}; cnt increments. bit_valid=0: both hold.
- Completion: bit_valid=1 with cnt=WIDTH-1 forms word {shreg[WIDTH-2:0], bit_in}; cnt wraps to 0 in the same edge.
- Output register FSM, two states:
  - EMPTY (word_valid=0): completion -> load word_out, go FULL.
  - FULL (word_valid=1): word_ready=1 and no completion -> EMPTY. word_ready=1 and completion same cycle -> load new word, stay FULL (no drop). word_ready=0 and completion -> word discarded, stay FULL, word_out unchanged, drop_count += 1 (saturating), overflow <= 1.
- word_out stable while word_valid=1 and word_ready=0.
- Bit assembly never stalls; a dropped word still resets cnt to 0 (next bit starts a fresh word).
- overflow clears only on rst; drop_count does not wrap.

## Timing
- Reset (rst=1 at an edge): cnt=0, shreg=0, word_out=0, word_valid=0, overflow=0, drop_count=0. Overrides all other inputs that cycle; partially assembled word discarded.
- Latency: word_valid rises on the edge that accepts the WIDTH-th bit (visible the following cycle); word_out valid in that same cycle.
- Handshake transfer occurs on an edge where word_valid=1 and word_ready=1; word_ready while word_valid=0 has no effect.
- Sustained throughput: one word per WIDTH valid bits with word_ready held high; no bubbles, no drops.
- drop_count and overflow update on the same edge as the discarded completion.

## Structure
- Shared package trng_pkg: TRNG_WORD_W = 8 (default for WIDTH), TRNG_DROP_W = 16, typedef trng_word_t (logic [TRNG_WORD_W-1:0]).
- Output FSM state type (EMPTY/FULL) local to the module; single-bit encoding acceptable.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count) for drop_count; reusable for other TRNG health counters.

## Test plan
- Reset/idle: assert rst 2 cycles, bit_valid=0 for 10 cycles -> word_valid=0, word_out=0, overflow=0, drop_count=0 throughout.
- Packing order: WIDTH=8, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hB2, word_valid high exactly 1 cycle after the 8th bit, then low.
- Gapped input: same 8 bits with bit_valid=0 inserted between every bit -> word_out=8'hB2 after 8th valid bit; gaps do not shift data.
- Backpressure/drop: word_ready=0, send 24 bits (words A5, 3C, FF) -> word_out stays A5, drop_count=2, overflow=1; then word_ready=1 for one cycle -> word_valid=0.
- Simultaneous drain and completion: word_valid=1 with 8'h11, word_ready=1 on the edge the 8th bit of 8'h22 arrives -> word_out=8'h22, word_valid=1, drop_count unchanged.
- Reset mid-word and saturation: 5 bits then rst -> next 8 bits form a word from scratch; with DROP_W=2 force 5 drops -> drop_count=3 (holds).

Source files
------------

// File: rtl/trng_pkg.sv
// ============================================================================
// Module      : trng_pkg
// Description : Shared widths and types for the TRNG datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trng_pkg;
    localparam int TRNG_WORD_W = 8;
    localparam int TRNG_DROP_W = 16;

    typedef logic [TRNG_WORD_W-1:0] trng_word_t;
endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; used for TRNG health stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

`default_nettype wire

// File: rtl/trng_deserializer.sv
// ============================================================================
// Module      : trng_deserializer
// Description : Packs the serial entropy bit stream into words behind a
//               one-entry valid/ready register; words that find it full are
//               dropped and counted so the bit source never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_deserializer
    import trng_pkg::*;
#(
    parameter int WIDTH  = TRNG_WORD_W,
    parameter int DROP_W = TRNG_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WIDTH-1:0]  word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overflow_q;
    logic             w_shift_valid;
    logic [WIDTH-1:0] w_shift;
    logic             w_complete;
    logic             w_drop;

    // The full shift value doubles as the completed word on the last bit.
    assign w_shift    = {shreg_q, bit_in};
    assign w_complete = bit_valid && (cnt_q == CNT_MAX);
    assign w_shift_valid = bit_valid;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (w_shift_valid) begin
            shreg_d = w_shift[WIDTH-2:0];
            cnt_d   = w_complete ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        w_drop  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (w_complete) begin
                    word_d  = w_shift;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    if (word_ready) begin
                        word_d = w_shift;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (word_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            overflow_q <= overflow_q | w_drop;
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_drop),
        .count (drop_count)
    );

    assign word_out   = word_q;
    assign word_valid = (state_q == ST_FULL);
    assign overflow   = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_trng_deserializer.sv
// ============================================================================
// Module      : tb_trng_deserializer
// Description : Scoreboard bench for trng_deserializer (default widths plus a
//               DROP_W=2 instance for counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_deserializer;
    import trng_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             word_ready;
    trng_word_t       word_out;
    logic             word_valid;
    logic             overflow;
    logic [15:0]      drop_count;

    logic             sat_ready;
    trng_word_t       sat_word_out;
    logic             sat_word_valid;
    logic             sat_overflow;
    logic [1:0]       sat_drop_count;

    int               n_checks = 0;
    int               n_fail   = 0;
    trng_word_t       sb_q[$];

    trng_deserializer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    trng_deserializer #(
        .WIDTH  (8),
        .DROP_W (2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (sat_word_out),
        .word_valid (sat_word_valid),
        .word_ready (sat_ready),
        .overflow   (sat_overflow),
        .drop_count (sat_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Sends MSB first; optional idle cycle before every bit.
    task automatic send_word(input trng_word_t w, input bit gap, input bit expect_out);
        for (int i = 7; i >= 0; i--) begin
            if (gap) tick();
            if (i == 0 && expect_out) sb_q.push_back(w);
            drive_bit(w[i]);
        end
    endtask

    // Transfer happens on the next rising edge when valid & ready here.
    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", {24'd0, word_out}, 32'hFFFF_FFFF);
            else                  chk("sb_word", {24'd0, word_out}, {24'd0, sb_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0; sat_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", {31'd0, word_valid}, 32'd0);
            chk("idle_word", {24'd0, word_out}, 32'd0);
            chk("idle_ovf", {31'd0, overflow}, 32'd0);
            chk("idle_drop", {16'd0, drop_count}, 32'd0);
        end

        word_ready = 1'b1;
        send_word(8'hB2, 1'b0, 1'b1);
        chk("pack_valid", {31'd0, word_valid}, 32'd1);
        chk("pack_word", {24'd0, word_out}, 32'hB2);
        tick();
        chk("pack_valid_low", {31'd0, word_valid}, 32'd0);

        send_word(8'hB2, 1'b1, 1'b1);
        chk("gap_valid", {31'd0, word_valid}, 32'd1);
        chk("gap_word", {24'd0, word_out}, 32'hB2);
        tick();

        word_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        chk("bp_valid", {31'd0, word_valid}, 32'd1);
        chk("bp_word", {24'd0, word_out}, 32'hA5);
        chk("bp_drop", {16'd0, drop_count}, 32'd2);
        chk("bp_ovf", {31'd0, overflow}, 32'd1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("bp_drain", {31'd0, word_valid}, 32'd0);

        send_word(8'h11, 1'b0, 1'b1);
        chk("sim_first", {24'd0, word_out}, 32'h11);
        for (int i = 7; i >= 1; i--) drive_bit(1'(8'h22 >> i));
        word_ready = 1'b1;
        sb_q.push_back(8'h22);
        drive_bit(1'b0);
        chk("sim_word", {24'd0, word_out}, 32'h22);
        chk("sim_valid", {31'd0, word_valid}, 32'd1);
        chk("sim_drop", {16'd0, drop_count}, 32'd2);
        tick();
        chk("sim_drained", {31'd0, word_valid}, 32'd0);

        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        send_word(8'hC3, 1'b0, 1'b1);
        chk("rst_word", {24'd0, word_out}, 32'hC3);
        tick();

        word_ready = 1'b0;
        for (int k = 0; k < 6; k++) send_word(trng_word_t'(8'h40 + k), 1'b0, 1'b0);
        chk("sat_main_drop", {16'd0, drop_count}, 32'd5);
        chk("sat_drop", {30'd0, sat_drop_count}, 32'd3);
        chk("sat_ovf", {31'd0, sat_overflow}, 32'd1);
        chk("sat_word", {24'd0, word_out}, 32'h40);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
